// File: rtl/game_timer_pkg.sv
// Shared types, constants and helpers for the N-digit BCD game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int             BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // At least one bit so a 1-cycle tick period still has a divider register.
  function automatic int div_width(input int freq);
    int w;
    w = $clog2(freq);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Decimal integer to packed BCD, up to eight digits.
  function automatic logic [31:0] to_bcd(input int value);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register: clamped load, increment with carry-out,
// decrement with borrow-out. Cells are chained LSD first by the top.
module bcd_digit_cell
  import game_timer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [BCD_W-1:0] digit_o,
  output logic [BCD_W-1:0] next_o,
  output logic             carry_o,
  output logic             borrow_o
);

  logic [BCD_W-1:0] digit_q, digit_d;

  // NOTE: digit_d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = clamp_digit(load_val_i);
    end else if (inc_i) begin
      digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 1'b1;
    end else if (dec_i) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign next_o   = digit_d;
  assign carry_o  = inc_i && !load_i && (digit_q == BCD_MAX);
  assign borrow_o = dec_i && !load_i && (digit_q == '0);

endmodule

// File: rtl/bcd_game_timer.sv
// N-digit BCD game timer: up to a limit or down to zero, with pause/resume,
// selectable tick rate and expiry pulse. Optional Warning output: GAME_TIMER_WARN_EN.
module bcd_game_timer
  import game_timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int DIGITS          = 2
`ifdef GAME_TIMER_WARN_EN
  ,
  parameter int WARN_THRESHOLD  = 10
`endif
) (
  input  logic                    ClockIn,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Pause,
  input  logic                    Load,
  input  logic [BCD_W*DIGITS-1:0] LoadValue,
  input  logic                    CountDown,
  input  logic [1:0]              Speed,
  output logic [BCD_W*DIGITS-1:0] CounterValue,
  output logic                    Running,
  output logic                    Tick,
  output logic                    Expired,
  output logic                    Done
`ifdef GAME_TIMER_WARN_EN
  ,
  output logic                    Warning
`endif
);

  localparam int CW    = BCD_W * DIGITS;
  localparam int DIV_W = div_width(CLOCK_FREQUENCY);

  // Divider reload for a tick period of CLOCK_FREQUENCY >> spd cycles (minimum 1).
  function automatic logic [DIV_W-1:0] reload_val(input logic [1:0] spd);
    int p;
    p = CLOCK_FREQUENCY >> spd;
    return (p > 0) ? DIV_W'(p - 1) : '0;
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    limit_q, limit_d;
  logic             mode_down_q, mode_down_d;
  logic             tick_q, tick_d;
  logic             expired_q, expired_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGITS:0]  carry, borrow;
  logic             load_ok, step;
  logic             at_term, step_term;

  // Load is ignored while running; a count step happens only on an unpaused divider expiry.
  assign load_ok = Load && (state_q != RUN);
  assign step    = (state_q == RUN) && !Pause && (div_q == '0);

  assign carry[0]  = step && !mode_down_q;
  assign borrow[0] = step &&  mode_down_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk_i      (ClockIn),
      .rst_i      (Reset),
      .load_i     (load_ok),
      .load_val_i (CountDown ? LoadValue[g*BCD_W +: BCD_W] : BCD_W'(0)),
      .inc_i      (carry[g]),
      .dec_i      (borrow[g]),
      .digit_o    (cnt_q[g*BCD_W +: BCD_W]),
      .next_o     (cnt_d[g*BCD_W +: BCD_W]),
      .carry_o    (carry[g+1]),
      .borrow_o   (borrow[g+1])
    );
  end

  // Overflow out of the top digit also counts as terminal, so the count can never wrap.
  assign at_term   = mode_down_q ? (cnt_q == '0) : (cnt_q == limit_q);
  assign step_term = mode_down_q ? ((cnt_d == '0) || borrow[DIGITS])
                                 : ((cnt_d == limit_q) || carry[DIGITS]);

`ifdef GAME_TIMER_WARN_EN
  localparam logic [CW-1:0] WARN_BCD = CW'(to_bcd(WARN_THRESHOLD));
  logic warn_q, warn_d;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    limit_d     = limit_q;
    mode_down_d = mode_down_q;
    tick_d      = 1'b0;
    expired_d   = 1'b0;
    if (load_ok) begin
      state_d     = IDLE;
      mode_down_d = CountDown;
      if (!CountDown) begin
        for (int i = 0; i < DIGITS; i++) begin
          limit_d[i*BCD_W +: BCD_W] = clamp_digit(LoadValue[i*BCD_W +: BCD_W]);
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Pause) begin
            if (at_term) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
              div_d   = reload_val(Speed);
            end
          end
        end
        RUN: begin
          if (Pause) begin
            state_d = PAUSED;
          end else if (step) begin
            div_d  = reload_val(Speed);
            tick_d = 1'b1;
            if (step_term) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        PAUSED: begin
          if (Start && !Pause) state_d = RUN;
        end
        default: ;
      endcase
    end
`ifdef GAME_TIMER_WARN_EN
    warn_d = ((state_d == RUN) || (state_d == PAUSED)) && mode_down_d &&
             (cnt_d != '0) && (cnt_d <= WARN_BCD);
`endif
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q     <= IDLE;
      div_q       <= reload_val(Speed);
      limit_q     <= '0;
      mode_down_q <= 1'b1;
      tick_q      <= 1'b0;
      expired_q   <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
      warn_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      limit_q     <= limit_d;
      mode_down_q <= mode_down_d;
      tick_q      <= tick_d;
      expired_q   <= expired_d;
`ifdef GAME_TIMER_WARN_EN
      warn_q      <= warn_d;
`endif
    end
  end

  assign CounterValue = cnt_q;
  assign Running      = (state_q == RUN);
  assign Done         = (state_q == DONE);
  assign Tick         = tick_q;
  assign Expired      = expired_q;
`ifdef GAME_TIMER_WARN_EN
  assign Warning      = warn_q;
`endif

endmodule
